// File: rtl/jups_io_unit.sv
// Jups core I/O unit: debounced IN handshake and sequential binary-to-BCD
// conversion feeding registered 7-segment outputs.

// Per-digit lane: BCD add-3 correction for the converter and segment decode
// for the display.
module jups_io_digit #(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] cnv_nib,
  output logic [3:0] cnv_adj,
  input  logic [3:0] disp_nib,
  input  logic       blank,
  input  logic       halt,
  output logic [6:0] seg
);
  logic [6:0] raw;

  assign cnv_adj = (cnv_nib >= 4'd5) ? cnv_nib + 4'd3 : cnv_nib;

  // active-high gfedcba pattern; dash wins over blanking while halted
  always_comb begin
    raw = 7'h00;
    if (halt) raw = 7'h40;
    else if (!blank) begin
      case (disp_nib)
        4'd0:    raw = 7'h3F;
        4'd1:    raw = 7'h06;
        4'd2:    raw = 7'h5B;
        4'd3:    raw = 7'h4F;
        4'd4:    raw = 7'h66;
        4'd5:    raw = 7'h6D;
        4'd6:    raw = 7'h7D;
        4'd7:    raw = 7'h07;
        4'd8:    raw = 7'h7F;
        4'd9:    raw = 7'h6F;
        default: raw = 7'h00;
      endcase
    end
  end

  assign seg = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
endmodule

module jups_io_unit #(
  parameter int DATA_W         = 32,
  parameter int SW_W           = 16,
  parameter int BIN_W          = 9,
  parameter int N_DIGITS       = 3,
  parameter int DB_CYCLES      = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Button,
  input  logic [SW_W-1:0]       Switches,
  input  logic                  InReq,
  output logic                  InAck,
  output logic [DATA_W-1:0]     InData,
  output logic                  Stall,
  input  logic                  OutWe,
  input  logic [DATA_W-1:0]     OutData,
  input  logic                  Halt,
  output logic                  Busy,
  output logic [7*N_DIGITS-1:0] Display
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int CW  = $clog2(BIN_W + 1);
  localparam int BW  = 4 * N_DIGITS;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNV_LAST = CW'(BIN_W - 1);

  // display image of a stored zero, honouring blanking and polarity
  function automatic logic [7*N_DIGITS-1:0] disp_rst_f();
    logic [7*N_DIGITS-1:0] v;
    logic [6:0]            d;
    v = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      d = (i == 0 || LZ_BLANK == 0) ? 7'h3F : 7'h00;
      v[7*i +: 7] = (SEG_ACTIVE_LOW != 0) ? ~d : d;
    end
    return v;
  endfunction
  localparam logic [7*N_DIGITS-1:0] DISP_RST = disp_rst_f();

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_ACK}  in_st_t;
  typedef enum logic [1:0] {O_IDLE, O_CONV, O_LOAD} out_st_t;

  in_st_t  in_st, in_nxt;
  out_st_t out_st, out_nxt;

  logic           s1, s2, btn_db, btn_db_q, btn_pulse;
  logic [DBW-1:0] db_cnt;

  logic [BIN_W-1:0] sh, pend;
  logic             pend_full;
  logic [BW-1:0]    bcd, bcd_adj, disp_bcd, disp_nxt;
  logic [CW-1:0]    cnv_cnt;

  logic [7*N_DIGITS-1:0] seg_nxt;
  logic [N_DIGITS:1]     lz;
  logic [N_DIGITS-1:0]   blank;

  logic unused_hi;
  assign unused_hi = ^OutData;

  // button: 2-FF synchroniser, then accept a level only after DB_CYCLES
  // consecutive samples that disagree with the current debounced value
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0; s2 <= 1'b0; btn_db <= 1'b0; btn_db_q <= 1'b0; db_cnt <= '0;
    end else begin
      s1       <= Button;
      s2       <= s1;
      btn_db_q <= btn_db;
      if (s2 == btn_db) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        btn_db <= s2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end

  assign btn_pulse = btn_db & ~btn_db_q;

  // IN FSM state register and switch capture on the accepted press
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      in_st  <= I_IDLE;
      InData <= '0;
    end else begin
      in_st <= in_nxt;
      if (in_st == I_WAIT && InReq && btn_pulse) InData <= DATA_W'(Switches);
    end
  end

  // IN FSM next state; abort takes precedence over a coincident press
  always_comb begin
    in_nxt = in_st;
    case (in_st)
      I_IDLE:  if (InReq) in_nxt = I_WAIT;
      I_WAIT:  if (!InReq) in_nxt = I_IDLE;
               else if (btn_pulse) in_nxt = I_ACK;
      I_ACK:   in_nxt = I_IDLE;
      default: in_nxt = I_IDLE;
    endcase
  end

  assign InAck = (in_st == I_ACK);
  assign Stall = InReq & ~InAck;

  // OUT FSM next state; a write during LOAD restarts conversion directly
  always_comb begin
    out_nxt = out_st;
    case (out_st)
      O_IDLE:  if (OutWe) out_nxt = O_CONV;
      O_CONV:  if (cnv_cnt == CNV_LAST) out_nxt = O_LOAD;
      O_LOAD:  out_nxt = (OutWe || pend_full) ? O_CONV : O_IDLE;
      default: out_nxt = O_IDLE;
    endcase
  end

  assign Busy = (out_st != O_IDLE);

  // conversion datapath: shift-add-3 engine, pending slot, stored BCD
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_st    <= O_IDLE;
      sh        <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      bcd       <= '0;
      disp_bcd  <= '0;
      cnv_cnt   <= '0;
    end else begin
      out_st <= out_nxt;
      case (out_st)
        O_IDLE: if (OutWe) begin
          sh      <= OutData[BIN_W-1:0];
          bcd     <= '0;
          cnv_cnt <= '0;
        end
        O_CONV: begin
          bcd     <= {bcd_adj[BW-2:0], sh[BIN_W-1]};
          sh      <= {sh[BIN_W-2:0], 1'b0};
          cnv_cnt <= cnv_cnt + 1'b1;
          if (OutWe) begin
            pend      <= OutData[BIN_W-1:0];
            pend_full <= 1'b1;
          end
        end
        O_LOAD: begin
          disp_bcd <= bcd;
          if (OutWe || pend_full) begin
            sh        <= OutWe ? OutData[BIN_W-1:0] : pend;
            bcd       <= '0;
            cnv_cnt   <= '0;
            pend_full <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign disp_nxt = (out_st == O_LOAD) ? bcd : disp_bcd;
  assign lz[N_DIGITS] = 1'b1;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    if (i > 0) begin : g_lz
      if (i < N_DIGITS) begin : g_chain
        if (i == N_DIGITS - 1) begin : g_top
          assign blank[i] = (LZ_BLANK != 0) && (disp_nxt[4*i +: 4] == 4'd0);
        end else begin : g_mid
          assign lz[i+1] = lz[i+2] & (disp_nxt[4*(i+1) +: 4] == 4'd0);
          assign blank[i] = (LZ_BLANK != 0) && lz[i+1] && (disp_nxt[4*i +: 4] == 4'd0);
        end
      end
    end else begin : g_units
      assign blank[i] = 1'b0;
    end

    jups_io_digit #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dig (
      .cnv_nib  (bcd[4*i +: 4]),
      .cnv_adj  (bcd_adj[4*i +: 4]),
      .disp_nib (disp_nxt[4*i +: 4]),
      .blank    (blank[i]),
      .halt     (Halt),
      .seg      (seg_nxt[7*i +: 7])
    );
  end

  if (N_DIGITS == 1) begin : g_lz1
    logic unused_lz;
    assign unused_lz = lz[1];
  end

  // registered segment outputs; only LOAD or a Halt change alters them
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) Display <= DISP_RST;
    else       Display <= seg_nxt;
  end
endmodule

// File: tb/tb_jups_io_unit.sv
// Directed bench for jups_io_unit (DB_CYCLES=4, other parameters default).
module tb_jups_io_unit;
  logic        Clock = 1'b0;
  logic        Reset, Button, InReq, OutWe, Halt;
  logic [15:0] Switches;
  logic [31:0] OutData;
  logic        InAck, Stall, Busy;
  logic [31:0] InData;
  logic [20:0] Display;

  int nchk = 0, nerr = 0;
  int acks = 0;
  logic [31:0] ack_data;
  logic        ack_stall;

  // active-low digits, {digit2, digit1, digit0}
  localparam logic [20:0] D000 = {7'h40, 7'h40, 7'h40};
  localparam logic [20:0] D255 = {7'h24, 7'h12, 7'h12};
  localparam logic [20:0] D123 = {7'h79, 7'h24, 7'h30};
  localparam logic [20:0] D007 = {7'h40, 7'h40, 7'h78};
  localparam logic [20:0] D042 = {7'h40, 7'h19, 7'h24};
  localparam logic [20:0] DASH = {7'h3F, 7'h3F, 7'h3F};

  jups_io_unit #(.DB_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset), .Button(Button), .Switches(Switches),
    .InReq(InReq), .InAck(InAck), .InData(InData), .Stall(Stall),
    .OutWe(OutWe), .OutData(OutData), .Halt(Halt), .Busy(Busy),
    .Display(Display)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // advance n cycles; the core side drops InReq as soon as it sees InAck
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (InAck) begin
        acks++;
        ack_data  = InData;
        ack_stall = Stall;
        InReq = 1'b0;
      end
    end
  endtask

  initial begin
    int nb, first;
    bit seen123, seen7;
    Reset = 1'b1; Button = 1'b0; InReq = 1'b0; OutWe = 1'b0; Halt = 1'b0;
    Switches = '0; OutData = '0;
    tick(); tick();
    chk("rst_busy",    Busy,    1'b0);
    chk("rst_inack",   InAck,   1'b0);
    chk("rst_indata",  InData,  32'h0);
    chk("rst_display", Display, D000);
    chk("rst_stall",   Stall,   1'b0);
    Reset = 1'b0;
    tick();

    // 1: clean press while waiting
    Switches = 16'h00A5; InReq = 1'b1; Button = 1'b1;
    acks = 0;
    run(1);
    chk("t1_stall_wait", Stall, 1'b1);
    run(5);
    Button = 1'b0;
    run(18);
    chk("t1_ack_count", acks, 1);
    chk("t1_indata", ack_data, 32'h000000A5);
    chk("t1_stall_at_ack", ack_stall, 1'b0);

    // 2: bounce, then early press in IDLE, then a real press
    acks = 0; Switches = 16'h005A; InReq = 1'b1;
    for (int r = 0; r < 3; r++) begin
      Button = 1'b1; run(2);
      Button = 1'b0; run(2);
    end
    run(10);
    chk("t2_bounce_noack", acks, 0);
    chk("t2_bounce_stall", Stall, 1'b1);
    InReq = 1'b0;
    run(1);
    chk("t2_abort_stall", Stall, 1'b0);
    Button = 1'b1; run(10);
    InReq = 1'b1; run(10);
    Button = 1'b0; run(10);
    chk("t2_early_discard", acks, 0);
    Button = 1'b1; run(6);
    Button = 1'b0; run(12);
    chk("t2_late_ack", acks, 1);
    chk("t2_late_data", ack_data, 32'h0000005A);

    // 3: single conversion, busy length and latency
    OutData = 32'd255; OutWe = 1'b1;
    tick();
    OutWe = 1'b0;
    nb = 0; first = -1;
    for (int k = 0; k < 20; k++) begin
      if (Busy) nb++;
      if (first < 0 && Display == D255) first = k;
      tick();
    end
    chk("t3_busy_cycles", nb, 10);
    chk("t3_latency", first, 10);
    chk("t3_display", Display, D255);

    // 4: writes while busy, last pending value wins
    OutData = 32'd123; OutWe = 1'b1; tick();
    OutWe = 1'b0; tick(); tick();
    OutData = 32'd7; OutWe = 1'b1; tick();
    OutWe = 1'b0; tick();
    OutData = 32'd42; OutWe = 1'b1; tick();
    OutWe = 1'b0;
    seen123 = 0; seen7 = 0;
    for (int k = 0; k < 40; k++) begin
      if (Display == D123) seen123 = 1;
      if (Display == D007) seen7 = 1;
      tick();
    end
    chk("t4_seen123", seen123, 1'b1);
    chk("t4_never7", seen7, 1'b0);
    chk("t4_final042", Display, D042);

    // 5: halt dashes, restore, conversion under halt
    Halt = 1'b1;
    chk("t5_halt_pre", Display, D042);
    tick();
    chk("t5_halt_dash", Display, DASH);
    Halt = 1'b0; tick();
    chk("t5_restore", Display, D042);
    Halt = 1'b1; tick();
    OutData = 32'd255; OutWe = 1'b1; tick();
    OutWe = 1'b0;
    run(15);
    chk("t5_dash_conv", Display, DASH);
    Halt = 1'b0; tick();
    chk("t5_restore_new", Display, D255);

    // 6: reset mid-conversion with IN waiting and a pending value
    OutData = 32'd123; OutWe = 1'b1; tick();
    OutData = 32'd7; tick();
    OutWe = 1'b0; InReq = 1'b1; tick(); tick();
    chk("t6_busy_before", Busy, 1'b1);
    #2 Reset = 1'b1;
    #1;
    chk("t6_rst_busy", Busy, 1'b0);
    chk("t6_rst_inack", InAck, 1'b0);
    chk("t6_rst_display", Display, D000);
    chk("t6_rst_indata", InData, 32'h0);
    tick();
    Reset = 1'b0; InReq = 1'b0; acks = 0;
    run(25);
    chk("t6_pend_dropped", Display, D000);
    chk("t6_idle_busy", Busy, 1'b0);
    chk("t6_no_ack", acks, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
